// File: rtl/offset_cal_sequencer.sv
// rtl/offset_cal_sequencer.sv - DC-offset calibration sequencer with saturating offset removal.
// Optional periodic recalibration is enabled by defining OFFSET_CAL_PERIODIC_EN.
module offset_cal_sequencer #(
  parameter int LOG2_N         = 4,
  parameter int SETTLE_SAMPLES = 8,
  parameter int RECAL_PERIOD   = 48000
) (
  input  logic               audio_clk,
  input  logic               rst_in,
  input  logic               sample_valid,
  input  logic signed [15:0] sample_in,
  input  logic               recal_req,
  output logic signed [15:0] audio_out,
  output logic               audio_valid,
  output logic signed [15:0] offset,
  output logic               offset_valid,
  output logic               offset_update,
  output logic               cal_busy
);

  localparam int AW = 16 + LOG2_N;
  localparam int SW = $clog2(SETTLE_SAMPLES) + 1;

  typedef enum logic [1:0] {ST_SETTLE, ST_ACCUM, ST_RUN} state_t;

  state_t                r_state;
  logic [SW-1:0]         r_settle_cnt;
  logic [LOG2_N-1:0]     r_acc_cnt;
  logic signed [AW-1:0]  r_acc;

  logic signed [AW-1:0]  w_sum;
  logic                  w_settle_done;
  logic                  w_acc_done;
  logic                  w_recal;
  logic signed [16:0]    w_diff;
  logic signed [15:0]    w_corr;

  assign w_sum         = r_acc + {{LOG2_N{sample_in[15]}}, sample_in};
  assign w_settle_done = sample_valid && (r_settle_cnt == SW'(SETTLE_SAMPLES - 1));
  assign w_acc_done    = sample_valid && (&r_acc_cnt);

`ifdef OFFSET_CAL_PERIODIC_EN
  localparam int PW = $clog2(RECAL_PERIOD + 1);
  logic [PW-1:0] r_run_cnt;
  logic          w_period_hit;
  assign w_period_hit = sample_valid && (r_run_cnt == PW'(RECAL_PERIOD - 1));
  assign w_recal      = recal_req || w_period_hit;
`else
  logic w_unused_period;
  assign w_unused_period = (RECAL_PERIOD != 0);
  assign w_recal         = recal_req;
`endif

  // 17-bit difference cannot wrap; clamp when the top two bits disagree
  assign w_diff = {sample_in[15], sample_in} - {offset[15], offset};
  always_comb begin
    w_corr = w_diff[15:0];
    if (w_diff[16] != w_diff[15])
      w_corr = w_diff[16] ? 16'sh8000 : 16'sh7FFF;
  end

  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      r_state       <= ST_SETTLE;
      r_settle_cnt  <= '0;
      r_acc_cnt     <= '0;
      r_acc         <= '0;
      offset        <= '0;
      offset_valid  <= 1'b0;
      offset_update <= 1'b0;
      cal_busy      <= 1'b1;
`ifdef OFFSET_CAL_PERIODIC_EN
      r_run_cnt     <= '0;
`endif
    end else begin
      offset_update <= 1'b0;
      case (r_state)
        ST_SETTLE: begin
          if (w_settle_done) begin
            r_state      <= ST_ACCUM;
            r_settle_cnt <= '0;
            r_acc        <= '0;
            r_acc_cnt    <= '0;
          end else if (sample_valid) begin
            r_settle_cnt <= r_settle_cnt + SW'(1);
          end
        end
        ST_ACCUM: begin
          if (sample_valid) begin
            r_acc     <= w_sum;
            r_acc_cnt <= r_acc_cnt + LOG2_N'(1);
          end
          // A recal_req coinciding with the final sample is intentionally dropped
          if (w_acc_done) begin
            offset        <= w_sum[AW-1:LOG2_N];
            offset_valid  <= 1'b1;
            offset_update <= 1'b1;
            cal_busy      <= 1'b0;
            r_state       <= ST_RUN;
`ifdef OFFSET_CAL_PERIODIC_EN
            r_run_cnt     <= '0;
`endif
          end
        end
        ST_RUN: begin
`ifdef OFFSET_CAL_PERIODIC_EN
          if (sample_valid)
            r_run_cnt <= r_run_cnt + PW'(1);
`endif
          if (w_recal) begin
            r_state      <= ST_SETTLE;
            r_settle_cnt <= '0;
            cal_busy     <= 1'b1;
          end
        end
        default: begin
          r_state  <= ST_SETTLE;
          cal_busy <= 1'b1;
        end
      endcase
    end
  end

  // Samples use the offset registered before this edge, so an update edge sees the old value
  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      audio_out   <= '0;
      audio_valid <= 1'b0;
    end else begin
      audio_valid <= sample_valid;
      if (sample_valid)
        audio_out <= offset_valid ? w_corr : sample_in;
    end
  end

endmodule
